// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: registered 4-bit BCD/hex to 7-segment decoder with blanking and polarity select
module bcd_to_7seg #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] bcd,
  input  logic       en,
  output logic [6:0] led_out
);
  logic [6:0] glyph;
  logic [6:0] off;
  assign off = {7{ACTIVE_LOW}};
  // glyph lookup in {a,b,c,d,e,f,g} order with lit = 1; every code 0-15 is mapped
  always_comb begin
    glyph = 7'b1000111;
    case (bcd)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'ha: glyph = 7'b1110111;
      4'hb: glyph = 7'b0011111;
      4'hc: glyph = 7'b1001110;
      4'hd: glyph = 7'b0111101;
      4'he: glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
  end
  // reset and en=0 both blank; polarity flip applied on the way into the register
  always_ff @(posedge clk)
    led_out <= (reset_n && en) ? glyph ^ off : off;
endmodule

// File: tb/tb_bcd_to_7seg.sv
// tb_bcd_to_7seg: table-driven and randomized checks of both display polarities
module tb_bcd_to_7seg;
  logic clk = 1'b0;
  logic reset_n, en;
  logic [3:0] bcd;
  logic [6:0] led_hi, led_lo;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bcd_to_7seg #(.ACTIVE_LOW(1'b0)) dut_hi (.clk(clk), .reset_n(reset_n), .bcd(bcd), .en(en), .led_out(led_hi));
  bcd_to_7seg #(.ACTIVE_LOW(1'b1)) dut_lo (.clk(clk), .reset_n(reset_n), .bcd(bcd), .en(en), .led_out(led_lo));

  typedef struct {
    logic       r;
    logic       e;
    logic [3:0] b;
    logic [6:0] x;
  } vec_t;
  vec_t tv[$];

  string segs[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] lit_of(input string s);
    logic [6:0] v = '0;
    for (int i = 0; i < s.len(); i++) v[6 - int'(s[i] - 8'h61)] = 1'b1;
    return v;
  endfunction

  function automatic logic [6:0] model(input logic r, input logic e, input logic [3:0] b);
    return (r && e) ? lit_of(segs[b]) : 7'b0000000;
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] b);
    @(negedge clk);
    reset_n = r;
    en = e;
    bcd = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string name, input logic [6:0] exp_lit);
    check({name, "_hi"}, led_hi, exp_lit);
    check({name, "_lo"}, led_lo, ~exp_lit);
  endtask

  initial begin
    logic r, e;
    logic [3:0] b;
    reset_n = 1'b0;
    en = 1'b1;
    bcd = 4'd8;
    for (int k = 0; k < 16; k++) tv.push_back('{1'b1, 1'b1, 4'(k), 7'b0});
    tv[0].x = 7'b1111110;  tv[1].x = 7'b0110000;  tv[2].x = 7'b1101101;  tv[3].x = 7'b1111001;
    tv[4].x = 7'b0110011;  tv[5].x = 7'b1011011;  tv[6].x = 7'b1011111;  tv[7].x = 7'b1110000;
    tv[8].x = 7'b1111111;  tv[9].x = 7'b1111011;  tv[10].x = 7'b1110111; tv[11].x = 7'b0011111;
    tv[12].x = 7'b1001110; tv[13].x = 7'b0111101; tv[14].x = 7'b1001111; tv[15].x = 7'b1000111;
    tv.push_back('{1'b1, 1'b0, 4'd8, 7'b0000000});
    tv.push_back('{1'b1, 1'b1, 4'd8, 7'b1111111});
    tv.push_back('{1'b1, 1'b1, 4'd3, 7'b1111001});
    tv.push_back('{1'b1, 1'b0, 4'd7, 7'b0000000});
    tv.push_back('{1'b1, 1'b1, 4'd7, 7'b1110000});
    tv.push_back('{1'b1, 1'b1, 4'd1, 7'b0110000});
    tv.push_back('{1'b0, 1'b1, 4'd8, 7'b0000000});
    tv.push_back('{1'b1, 1'b0, 4'd0, 7'b0000000});

    step(1'b0, 1'b1, 4'd8);
    check_both("reset1", 7'b0000000);
    step(1'b0, 1'b1, 4'd8);
    check_both("reset2", 7'b0000000);
    step(1'b1, 1'b1, 4'd8);
    check_both("release", 7'b1111111);

    foreach (tv[i]) begin
      step(tv[i].r, tv[i].e, tv[i].b);
      check_both($sformatf("vec%0d", i), tv[i].x);
    end

    step(1'b1, 1'b1, 4'd4);
    check_both("mid_pre", 7'b0110011);
    step(1'b0, 1'b1, 4'd5);
    check_both("mid_rst", 7'b0000000);
    step(1'b1, 1'b1, 4'd5);
    check_both("mid_resume", 7'b1011011);

    for (int n = 0; n < 300; n++) begin
      r = ($urandom % 8) != 0;
      e = ($urandom % 4) != 0;
      b = 4'($urandom);
      step(r, e, b);
      check_both($sformatf("rand%0d", n), model(r, e, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
